// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner selection for the shared 8-bit uio bus.
// Each ownership is capped at MAX_HOLD cycles. TA_CYCLES turnaround cycles
// with uio_oe=0 separate consecutive owners.
// Optional build macro ARB_PRIORITY0_EN: requester 0 always wins arbitration
// and pre-empts any other owner.
module uio_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_HOLD  = 16,
    parameter int TA_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   oe_mask,
    output logic [N_REQ-1:0]     gnt,
    output logic [2:0]           gnt_id,
    output logic                 busy,
    output logic [7:0]           uio_oe,
    output logic                 timeout
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam int TW = $clog2(TA_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t             state, state_n;
    logic [HW-1:0]      hold_cnt, hold_n;
    logic [TW-1:0]      ta_cnt, ta_n;
    logic [2:0]         last_id, last_n;
    logic [N_REQ-1:0]   gnt_n;
    logic [2:0]         gnt_id_n;
    logic [7:0]         oe_n;
    logic               timeout_n;

    logic               found;
    logic [2:0]         winner;
    logic [N_REQ-1:0]   win_onehot;
    logic [7:0]         win_mask;
    logic               owner_req;
    logic [7:0]         owner_mask;
    logic               preempt;
    logic               hold_hit;

    // Round-robin search from last_id+1. Pass one covers indices above last_id.
    // Pass two takes the lowest index overall, which is the wrapped continuation.
    always_comb begin
        found  = 1'b0;
        winner = '0;
`ifdef ARB_PRIORITY0_EN
        if (req[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!found && req[j] && (j > 32'(last_id))) begin
                found  = 1'b1;
                winner = 3'(j);
            end
        end
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = 3'(j);
            end
        end
    end

    // Decode the winner and the current owner (last_id) into request, mask and one-hot views
    always_comb begin
        win_onehot = '0;
        win_mask   = '0;
        owner_req  = 1'b0;
        owner_mask = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (3'(j) == winner) begin
                win_onehot[j] = 1'b1;
                win_mask      = oe_mask[8*j +: 8];
            end
            if (3'(j) == last_id) begin
                owner_req  = req[j];
                owner_mask = oe_mask[8*j +: 8];
            end
        end
    end

    // Conditions that can end an ownership
    always_comb begin
`ifdef ARB_PRIORITY0_EN
        preempt = req[0] && (last_id != 3'd0);
`else
        preempt = 1'b0;
`endif
        hold_hit = (hold_cnt == HW'(MAX_HOLD - 1));
    end

    // Next-state and registered-output decode
    always_comb begin
        state_n   = state;
        hold_n    = hold_cnt;
        ta_n      = ta_cnt;
        last_n    = last_id;
        gnt_n     = '0;
        gnt_id_n  = '0;
        oe_n      = '0;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (ena && found) begin
                    state_n  = GRANT;
                    hold_n   = '0;
                    last_n   = winner;
                    gnt_n    = win_onehot;
                    gnt_id_n = winner;
                    oe_n     = win_mask;
                end
            end
            GRANT: begin
                if (!owner_req || !ena || preempt || hold_hit) begin
                    state_n   = TURN;
                    ta_n      = '0;
                    // Release, abort and pre-emption all take precedence over the hold limit
                    timeout_n = hold_hit && owner_req && ena && !preempt;
                end else begin
                    hold_n   = hold_cnt + 1'b1;
                    gnt_n    = gnt;
                    gnt_id_n = gnt_id;
                    oe_n     = owner_mask;
                end
            end
            TURN: begin
                ta_n = ta_cnt + 1'b1;
                if (ta_cnt == TW'(TA_CYCLES - 1)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers. Reset returns the arbiter to IDLE with requester 0 next in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            ta_cnt   <= '0;
            last_id  <= 3'(N_REQ - 1);
            gnt      <= '0;
            gnt_id   <= '0;
            uio_oe   <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            ta_cnt   <= ta_n;
            last_id  <= last_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            uio_oe   <= oe_n;
            timeout  <= timeout_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Testbench for uio_bus_arbiter with N_REQ=4, MAX_HOLD=4 and TA_CYCLES=1.
// A cycle-level ownership model in the bench checks the DUT on every negedge.
// Directed literal checks at key points pin the model.
module tb_uio_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;
    localparam int TA = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [31:0] oe_mask;
    logic [3:0]  gnt;
    logic [2:0]  gnt_id;
    logic        busy;
    logic [7:0]  uio_oe;
    logic        timeout;

    int n_vec = 0;
    int n_bad = 0;

    uio_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH), .TA_CYCLES(TA)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .oe_mask(oe_mask),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .uio_oe(uio_oe), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership model: who owns the bus, for how many cycles, and how much turnaround remains
    int         m_owner;
    int         m_cycles;
    int         m_turn;
    int         m_last;
    int         m_win;
    int         m_cand;
    logic [7:0] m_oe;
    logic       m_tp;
    bit         m_rel;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_cycles = 0; m_turn = 0; m_last = N - 1;
            m_oe = 8'h00; m_tp = 1'b0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_owner >= 0) begin
                m_rel = !req[m_owner] || !ena;
`ifdef ARB_PRIORITY0_EN
                if (m_owner != 0 && req[0]) m_rel = 1'b1;
`endif
                if (m_rel || m_cycles == MH) begin
                    m_tp    = !m_rel;
                    m_owner = -1;
                    m_turn  = TA;
                end else begin
                    m_cycles++;
                    m_oe = oe_mask[8*m_owner +: 8];
                end
            end else if (m_turn > 0) begin
                m_turn--;
                m_tp = 1'b0;
            end else if (ena && req != 4'b0) begin
                m_win = -1;
`ifdef ARB_PRIORITY0_EN
                if (req[0]) m_win = 0;
`endif
                for (int k = 1; k <= N; k++) begin
                    m_cand = (m_last + k) % N;
                    if (m_win < 0 && req[m_cand]) m_win = m_cand;
                end
                m_owner  = m_win;
                m_last   = m_win;
                m_cycles = 1;
                m_oe     = oe_mask[8*m_win +: 8];
            end
        end
    end

    // Compare the DUT against the model on every cycle after the first reset
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_gnt",     32'(gnt),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("m_gnt_id",  32'(gnt_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            chk("m_busy",    32'(busy),    32'((m_owner >= 0) || (m_turn > 0)));
            chk("m_uio_oe",  32'(uio_oe),  (m_owner >= 0) ? 32'(m_oe) : 32'd0);
            chk("m_timeout", 32'(timeout), 32'(m_tp));
        end
    end

    initial begin
        rst = 1'b1; ena = 1'b0; req = 4'b0000;
        oe_mask = {8'hA5, 8'h3C, 8'h0F, 8'hF0};
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_oe", 32'(uio_oe), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // First grant goes to requester 0 one edge after the request
        rst = 1'b0; ena = 1'b1; req = 4'b0001;
        @(negedge clk);
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_id", 32'(gnt_id), 32'd0);
        chk("first_oe", 32'(uio_oe), 32'hF0);
        chk("first_busy", 32'(busy), 32'd1);

        // All requesters active: rotation with hold-limit handoffs
        req = 4'b1111;
        repeat (30) @(negedge clk);
        req = 4'b0000;
        repeat (8) @(negedge clk);

        // Early release by owner 2
        req = 4'b0100;
        @(negedge clk);
        chk("rel_gnt2", 32'(gnt), 32'h4);
        repeat (2) @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        chk("rel_gnt_off", 32'(gnt), 32'd0);
        chk("rel_no_timeout", 32'(timeout), 32'd0);
        repeat (2) @(negedge clk);
`ifdef ARB_PRIORITY0_EN
        chk("rel_next_owner", 32'(gnt), 32'h1);
`else
        chk("rel_next_owner", 32'(gnt), 32'h8);
`endif
        req = 4'b0001;
        repeat (6) @(negedge clk);
        req = 4'b0000;
        repeat (8) @(negedge clk);

        // Enable dropped for one cycle mid-grant
        req = 4'b1111;
        repeat (2) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        repeat (10) @(negedge clk);
        req = 4'b0000;
        repeat (8) @(negedge clk);

        // Reset during a grant of requester 0
        req = 4'b0001;
        @(negedge clk);
        chk("mid_oe", 32'(uio_oe), 32'hF0);
        req = 4'b1111; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_oe", 32'(uio_oe), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_regrant", 32'(gnt), 32'h1);
        req = 4'b0000;
        repeat (8) @(negedge clk);

        // Requester 0 arrives while owner 2 holds the bus
        req = 4'b0100;
        @(negedge clk);
        chk("pri_gnt2", 32'(gnt), 32'h4);
        @(negedge clk);
        req = 4'b1101;
        repeat (3) @(negedge clk);
`ifdef ARB_PRIORITY0_EN
        chk("pri_gnt0", 32'(gnt), 32'h1);
        chk("pri_no_timeout", 32'(timeout), 32'd0);
`else
        chk("pri_gnt_off", 32'(gnt), 32'd0);
        chk("pri_timeout", 32'(timeout), 32'd1);
        repeat (2) @(negedge clk);
        chk("pri_gnt3", 32'(gnt), 32'h8);
`endif
        req = 4'b0000;
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
